seq_shift_unit: RTL and testbench

SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

---
 rtl/seq_shift_pkg.sv | 22 ++
 rtl/shift_step.sv | 24 ++
 rtl/seq_shift_unit.sv | 86 ++++++++
 tb/tb_seq_shift_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_pkg.sv
// Shared definitions for the sequential shift unit: opcodes, op enum and FSM states.
package seq_shift_pkg;

  localparam logic [1:0] OPC_SLL = 2'b00;
  localparam logic [1:0] OPC_SRL = 2'b01;
  localparam logic [1:0] OPC_SRA = 2'b10;
  localparam logic [1:0] OPC_ROL = 2'b11;

  typedef enum logic [1:0] {
    OP_SLL = OPC_SLL,
    OP_SRL = OPC_SRL,
    OP_SRA = OPC_SRA,
    OP_ROL = OPC_ROL
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step of the working register for each shift operation.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] stepped
);

  // NOTE: assign a default before the case so every path drives the output and no latch is inferred.
  always_comb begin
    stepped = value;
    case (op)
      OPC_SLL: stepped = {value[WIDTH-2:0], 1'b0};
      OPC_SRL: stepped = {1'b0, value[WIDTH-1:1]};
      OPC_SRA: stepped = {value[WIDTH-1], value[WIDTH-1:1]};
      OPC_ROL: stepped = {value[WIDTH-2:0], value[WIDTH-1]};
      default: stepped = value;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: one bit per cycle, valid/ready handshake on both sides.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMTW-1:0]  in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam logic [AMTW-1:0] WIDTH_AMT = AMTW'(WIDTH);

  shift_state_e     state, state_nx;
  shift_op_e        op_q;
  logic [AMTW-1:0]  cnt;
  logic [AMTW-1:0]  n_accept;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] stepped;
  logic             accept;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_data  = out_valid ? work : '0;
  assign accept    = in_valid && in_ready;

  // Linear shifts saturate at WIDTH steps; rotates only need the residue.
  always_comb begin
    n_accept = (in_amt > WIDTH_AMT) ? WIDTH_AMT : in_amt;
    if (in_op == OPC_ROL)
      n_accept = in_amt % WIDTH_AMT;
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .value   (work),
    .stepped (stepped)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = (n_accept == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (cnt == AMTW'(1)) state_nx = ST_DONE;
      ST_DONE:  if (out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op_q  <= OP_SLL;
      cnt   <= '0;
      work  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            work <= in_data;
            op_q <= shift_op_e'(in_op);
            cnt  <= n_accept;
          end
        end
        ST_SHIFT: begin
          work <= stepped;
          cnt  <= cnt - AMTW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed-vector bench for seq_shift_unit with hand-computed results and latencies.
module tb_seq_shift_unit;

  localparam int WIDTH = 32;
  localparam int AMTW  = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic [AMTW-1:0]  in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  int errors = 0;
  int checks = 0;

  seq_shift_unit #(.WIDTH(WIDTH), .AMTW(AMTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with the unit idle again.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] data,
                        input logic [5:0] amt, input logic [31:0] exp_d, input int exp_lat);
    int lat;
    bit seen;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    in_amt   = amt;
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_data"}, 64'(out_data), 64'(exp_d));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drained"}, {62'd0, out_valid, busy}, 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_data   = '0;
    in_amt    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;

    // Accept on the first edge after reset release.
    run_op("sll_9_1",     2'b00, 32'h0000_0009, 6'd1,  32'h0000_0012, 2);
    run_op("sra_fffe_1",  2'b10, 32'hFFFF_FFFE, 6'd1,  32'hFFFF_FFFF, 2);
    run_op("sra_1_1",     2'b10, 32'h0000_0001, 6'd1,  32'h0000_0000, 2);
    run_op("srl_sat_40",  2'b01, 32'h8000_0000, 6'd40, 32'h0000_0000, 33);
    run_op("rol_33",      2'b11, 32'h8000_0001, 6'd33, 32'h0000_0003, 2);
    run_op("rol_32",      2'b11, 32'h8000_0001, 6'd32, 32'h8000_0001, 1);
    run_op("sll_0",       2'b00, 32'h0000_1234, 6'd0,  32'h0000_1234, 1);
    run_op("sra_sat_63",  2'b10, 32'h8000_0000, 6'd63, 32'hFFFF_FFFF, 33);
    run_op("srl_4",       2'b01, 32'hF000_0000, 6'd4,  32'h0F00_0000, 5);
    run_op("sra_4",       2'b10, 32'h8000_0000, 6'd4,  32'hF800_0000, 5);
    run_op("rol_8",       2'b11, 32'h1234_5678, 6'd8,  32'h3456_7812, 9);
    run_op("sll_sat_32",  2'b00, 32'hFFFF_FFFF, 6'd32, 32'h0000_0000, 33);
    run_op("rol_63",      2'b11, 32'h0000_00A5, 6'd63, 32'h8000_0052, 32);

    // Back-pressure in DONE with in_valid pulsed; it must not start a second operation.
    begin
      int lat;
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_data  = 32'h0000_0001;
      in_amt   = 6'd3;
      @(posedge clk);
      lat = 0;
      while (!out_valid && lat < 100) begin
        @(negedge clk);
        in_valid = 1'b0;
        lat++;
      end
      check("stall_lat", 64'(lat), 64'd4);
      for (int i = 0; i < 5; i++) begin
        in_valid = (i != 1);
        in_data  = 32'hDEAD_BEEF;
        in_amt   = 6'd0;
        @(posedge clk);
        @(negedge clk);
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'h8);
        check("stall_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        check("stall_single_result", {62'd0, out_valid, busy}, 64'd0);
        @(negedge clk);
      end
    end

    // Reset asserted mid-SHIFT: aborted result never appears.
    in_valid = 1'b1;
    in_op    = 2'b00;
    in_data  = 32'h0000_0001;
    in_amt   = 6'd20;
    @(posedge clk);
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check("mid_shift_busy", 64'(busy), 64'd1);
    check("mid_shift_data_masked", 64'(out_data), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_held_valid", 64'(out_valid), 64'd0);
    end
    rst_n = 1'b1;
    run_op("post_abort_srl", 2'b01, 32'h0000_0100, 6'd4, 32'h0000_0010, 5);

    // Reset asserted while a result waits in DONE.
    in_valid = 1'b1;
    in_op    = 2'b11;
    in_data  = 32'hCAFE_0001;
    in_amt   = 6'd32;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("done_wait_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_done_valid", 64'(out_valid), 64'd0);
    check("abort_done_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_abort_rol", 2'b11, 32'h8000_0001, 6'd1, 32'h0000_0003, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
